text_mem_loader: RTL and testbench

- Boot-time writer for the instruction (text) memory.
- Consumes a byte stream from the UART receiver over a valid/ready handshake, framed as sync + length + payload + checksum.
- Assembles little-endian 32-bit words and drives the text memory write port.
- Holds the core in reset until a frame completes with a correct checksum.

---
 rtl/text_mem_loader_pkg.sv | 18 +
 rtl/text_mem_loader_if.sv | 12 +
 rtl/text_mem_loader_word_assembler.sv | 39 +++
 rtl/text_mem_loader.sv | 145 ++++++++++++++
 tb/tb_text_mem_loader.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_mem_loader_pkg.sv
// text_loader_pkg: shared types and constants for the text memory loader.
// Holds the loader state encoding, default sync marker and length width.
package text_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int LEN_WIDTH = 16;

endpackage

// File: rtl/text_mem_loader_if.sv
// text_mem_loader_if: byte stream from the UART receiver.
// A transfer happens on a clock edge where valid and ready are both high.
interface text_mem_loader_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/text_mem_loader_word_assembler.sv
// word_assembler: little-endian byte-to-word packer with running XOR.
// Cleared by the loader FSM when a frame length has been received.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_rdy,
  output logic [7:0]  csum,
  output logic        full
);

  logic [1:0] idx;

  assign full = (idx == 2'd3);

  // Fill lanes in arrival order; pulse word_rdy after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      word     <= '0;
      word_rdy <= 1'b0;
      csum     <= '0;
    end else begin
      word_rdy <= byte_vld && full;
      if (clr) begin
        idx  <= '0;
        csum <= '0;
      end else if (byte_vld) begin
        word[{idx, 3'b000} +: 8] <= byte_in;
        idx  <= idx + 2'd1;
        csum <= csum ^ byte_in;
      end
    end
  end

endmodule

// File: rtl/text_mem_loader.sv
// text_mem_loader: boot-time text memory writer fed by a framed byte stream.
// Optional inter-byte timeout is built when TEXT_LOADER_TIMEOUT_EN is defined.
module text_mem_loader
  import text_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  text_mem_loader_if.slave      rx,
  input  logic                  start,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [31:0]           w_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  state_t state, nstate;

  logic                  rdy_q;
  logic                  acc;
  logic                  clr;
  logic                  byte_vld;
  logic                  full;
  logic                  last_word;
  logic                  len_big;
  logic                  in_frame;
  logic                  to_hit;
  logic [7:0]            len_lo;
  logic [7:0]            csum;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  n_now;
  logic [ADDR_WIDTH-1:0] wcnt;

  assign rx.ready  = rdy_q;
  assign acc       = rx.valid & rdy_q;
  assign n_now     = {rx.data, len_lo};
  assign len_big   = 32'(n_now) > (32'd1 << ADDR_WIDTH);
  assign last_word = LEN_WIDTH'(wcnt) == (len - LEN_WIDTH'(1));
  assign in_frame  = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign clr       = acc && (state == LEN_HI);
  assign byte_vld  = acc && (state == DATA);

  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .byte_vld (byte_vld),
    .byte_in  (rx.data),
    .word     (w_data),
    .word_rdy (w_en),
    .csum     (csum),
    .full     (full)
  );

`ifdef TEXT_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // Idle cycles since the last accepted byte of an open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_frame || acc) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign to_hit = in_frame && !acc &&
                  (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;

  // Timeout disabled: parameter kept so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_to_unused
  end
`endif

  // Frame parser next state.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (acc && rx.data == SYNC_BYTE) nstate = LEN_LO;
      LEN_LO:  if (acc) nstate = LEN_HI;
      LEN_HI: begin
        if (acc) begin
          if (len_big)           nstate = ERR;
          else if (n_now == '0)  nstate = CSUM;
          else                   nstate = DATA;
        end
      end
      DATA:    if (acc && full && last_word) nstate = CSUM;
      CSUM:    if (acc) nstate = (rx.data == csum) ? DONE : ERR;
      DONE,
      ERR:     if (start) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (to_hit) nstate = ERR;
  end

  // State, length capture and word address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_lo <= '0;
      len    <= '0;
      wcnt   <= '0;
      w_addr <= '0;
    end else begin
      state <= nstate;
      if (acc && state == LEN_LO) len_lo <= rx.data;
      if (clr) begin
        len  <= n_now;
        wcnt <= '0;
      end
      if (byte_vld && full) begin
        w_addr <= wcnt;
        wcnt   <= wcnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered status outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b1;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rdy_q     <= nstate inside {IDLE, LEN_LO, LEN_HI, DATA, CSUM};
      core_hold <= nstate != DONE;
      load_done <= nstate == DONE;
      load_err  <= nstate == ERR;
    end
  end

endmodule

// File: tb/tb_text_mem_loader.sv
// tb_text_mem_loader: randomized self-checking bench for text_mem_loader.
// Frames are checked against a byte-level frame parser model.
module tb_text_mem_loader;

  localparam int AW = 12;
`ifdef TEXT_LOADER_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1000000;
`endif

  typedef logic [7:0]     bq_t[$];
  typedef logic [AW+31:0] wq_t[$];
  typedef logic [31:0]    lq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          core_hold;
  logic          load_done;
  logic          load_err;

  int  n_chk = 0;
  int  n_fail = 0;
  wq_t got_q;

  text_mem_loader_if rxif ();

  text_mem_loader #(
    .ADDR_WIDTH     (AW),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rxif),
    .start     (start),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && w_en === 1'b1) got_q.push_back({w_addr, w_data});

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  // Reference: parse a byte stream by the frame rules.
  // st: 0 incomplete, 1 loaded ok, 2 aborted.
  task automatic model(input bq_t b, output wq_t w, output int st);
    int i;
    int n;
    logic [7:0] x;
    w  = {};
    st = 0;
    i  = 0;
    x  = 8'h00;
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i + 2 >= b.size()) return;
    n = int'({b[i+2], b[i+1]});
    i += 3;
    if (n > (1 << AW)) begin
      st = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (i + 4 > b.size()) return;
      w.push_back({AW'(k), b[i+3], b[i+2], b[i+1], b[i]});
      x ^= b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
      i += 4;
    end
    if (i >= b.size()) return;
    st = (b[i] == x) ? 1 : 2;
  endtask

  function automatic bq_t make_frame(input lq_t w);
    bq_t f;
    logic [7:0] x;
    x = 8'h00;
    f.push_back(8'hA5);
    f.push_back(8'(w.size()));
    f.push_back(8'(w.size() >> 8));
    foreach (w[k]) begin
      for (int j = 0; j < 4; j++) begin
        f.push_back(w[k][8*j +: 8]);
        x ^= w[k][8*j +: 8];
      end
    end
    f.push_back(x);
    return f;
  endfunction

  task automatic send(input bq_t b, input int maxgap, input bit noise);
    bit ok;
    foreach (b[i]) begin
      rxif.data  = b[i];
      rxif.valid = 1'b1;
      start = noise && ($urandom_range(0, 7) == 0);
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        ok = rxif.ready;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      rxif.valid = 1'b0;
      if (!ok) begin
        n_chk++;
        n_fail++;
        $display("FAIL send: byte %0d got no ready expected accept", i);
        return;
      end
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rxif.data  = 8'h00;
    rxif.valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (rxif.ready !== 1'b1) begin n_fail++; $display("FAIL rst.ready: got %b expected 1", rxif.ready); end
    n_chk++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL rst.w_en: got %b expected 0", w_en); end
    n_chk++; if (w_addr !== '0) begin n_fail++; $display("FAIL rst.w_addr: got %h expected 0", w_addr); end
    n_chk++; if (w_data !== '0) begin n_fail++; $display("FAIL rst.w_data: got %h expected 0", w_data); end
    n_chk++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL rst.hold: got %b expected 1", core_hold); end
    n_chk++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst.done: got %b expected 0", load_done); end
    n_chk++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst.err: got %b expected 0", load_err); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    for (int c = 0; c < 3; c++) begin
      bq_t f;
      bq_t g;
      lq_t wl;
      wq_t ew;
      int  st;
      case (c)
        0, 1: begin
          wl.push_back(32'h00100513);
          wl.push_back(32'h00200593);
          f = make_frame(wl);
          if (c == 1) f[f.size()-1] = 8'h00;
        end
        default: begin
          f.push_back(8'h00);
          f.push_back(8'hFF);
          f.push_back(8'h5A);
          wl.push_back(32'hDEADBEEF);
          g = make_frame(wl);
          foreach (g[k]) f.push_back(g[k]);
        end
      endcase
      model(f, ew, st);
      got_q.delete();
      send(f, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (got_q.size() != ew.size()) begin
        n_fail++;
        $display("FAIL dir%0d.nwr: got %0d expected %0d", c, got_q.size(), ew.size());
      end
      foreach (ew[k]) begin
        n_chk++;
        if (k >= got_q.size() || got_q[k] !== ew[k]) begin
          n_fail++;
          $display("FAIL dir%0d.wr%0d: got %h expected %h", c, k,
                   (k < got_q.size()) ? got_q[k] : 'x, ew[k]);
        end
      end
      n_chk++;
      if ({load_done, load_err, core_hold, rxif.ready} !==
          {st == 1, st == 2, st != 1, st == 0}) begin
        n_fail++;
        $display("FAIL dir%0d.status: got %b%b%b%b expected st=%0d", c,
                 load_done, load_err, core_hold, rxif.ready, st);
      end
      if (st != 0) begin
        pulse_start();
        n_chk++;
        if ({load_done, load_err, core_hold, rxif.ready} !== 4'b0011) begin
          n_fail++;
          $display("FAIL dir%0d.rearm: got %b%b%b%b expected 0011", c,
                   load_done, load_err, core_hold, rxif.ready);
        end
      end
    end
  endtask

  task automatic test_length();
    for (int c = 0; c < 2; c++) begin
      bq_t f;
      wq_t ew;
      int  st;
      f.push_back(8'hA5);
      if (c == 0) begin
        f.push_back(8'h01);
        f.push_back(8'h10);
      end else begin
        f.push_back(8'h00);
        f.push_back(8'h00);
        f.push_back(8'h00);
      end
      model(f, ew, st);
      got_q.delete();
      send(f, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (got_q.size() != ew.size()) begin
        n_fail++;
        $display("FAIL len%0d.nwr: got %0d expected %0d", c, got_q.size(), ew.size());
      end
      n_chk++;
      if ({load_done, load_err, core_hold, rxif.ready} !==
          {st == 1, st == 2, st != 1, st == 0}) begin
        n_fail++;
        $display("FAIL len%0d.status: got %b%b%b%b expected st=%0d", c,
                 load_done, load_err, core_hold, rxif.ready, st);
      end
      pulse_start();
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 12; r++) begin
      bq_t f;
      bq_t g;
      lq_t wl;
      wq_t ew;
      int  st;
      logic [7:0] gb;
      repeat ($urandom_range(0, 3)) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h3C;
        f.push_back(gb);
      end
      repeat ($urandom_range(1, 6)) wl.push_back($urandom());
      g = make_frame(wl);
      if ($urandom_range(0, 3) == 0)
        g[g.size()-1] ^= 8'($urandom_range(1, 255));
      foreach (g[k]) f.push_back(g[k]);
      model(f, ew, st);
      got_q.delete();
      send(f, 3, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (got_q.size() != ew.size()) begin
        n_fail++;
        $display("FAIL rnd%0d.nwr: got %0d expected %0d", r, got_q.size(), ew.size());
      end
      foreach (ew[k]) begin
        n_chk++;
        if (k >= got_q.size() || got_q[k] !== ew[k]) begin
          n_fail++;
          $display("FAIL rnd%0d.wr%0d: got %h expected %h", r, k,
                   (k < got_q.size()) ? got_q[k] : 'x, ew[k]);
        end
      end
      n_chk++;
      if ({load_done, load_err, core_hold, rxif.ready} !==
          {st == 1, st == 2, st != 1, st == 0}) begin
        n_fail++;
        $display("FAIL rnd%0d.status: got %b%b%b%b expected st=%0d", r,
                 load_done, load_err, core_hold, rxif.ready, st);
      end
      pulse_start();
    end
  endtask

  task automatic test_midreset();
    bq_t f;
    bq_t p;
    lq_t wl;
    wq_t ew;
    int  st;
    repeat (3) wl.push_back($urandom());
    f = make_frame(wl);
    for (int k = 0; k < 9; k++) p.push_back(f[k]);
    send(p, 4, 1'b0);
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({rxif.ready, w_en, core_hold, load_done, load_err} !== 5'b10100) begin
      n_fail++;
      $display("FAIL mrst.ctl: got %b%b%b%b%b expected 10100", rxif.ready,
               w_en, core_hold, load_done, load_err);
    end
    n_chk++;
    if ({w_addr, w_data} !== '0) begin
      n_fail++;
      $display("FAIL mrst.bus: got %h expected 0", {w_addr, w_data});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    wl.delete();
    repeat (2) wl.push_back($urandom());
    f = make_frame(wl);
    model(f, ew, st);
    send(f, 4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (got_q.size() != ew.size()) begin
      n_fail++;
      $display("FAIL mrst.nwr: got %0d expected %0d", got_q.size(), ew.size());
    end
    foreach (ew[k]) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== ew[k]) begin
        n_fail++;
        $display("FAIL mrst.wr%0d: got %h expected %h", k,
                 (k < got_q.size()) ? got_q[k] : 'x, ew[k]);
      end
    end
    n_chk++;
    if ({load_done, load_err, core_hold} !== {st == 1, st == 2, st != 1}) begin
      n_fail++;
      $display("FAIL mrst.status: got %b%b%b expected st=%0d",
               load_done, load_err, core_hold, st);
    end
    pulse_start();
  endtask

`ifdef TEXT_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bq_t f;
    bq_t p;
    bq_t q;
    lq_t wl;
    wq_t ew;
    int  st;
    p.push_back(8'hA5);
    p.push_back(8'h01);
    got_q.delete();
    send(p, 0, 1'b0);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if ({load_done, load_err, core_hold, rxif.ready} !== 4'b0110) begin
      n_fail++;
      $display("FAIL to16.status: got %b%b%b%b expected 0110",
               load_done, load_err, core_hold, rxif.ready);
    end
    pulse_start();
    wl.push_back(32'hCAFEF00D);
    f = make_frame(wl);
    model(f, ew, st);
    for (int k = 2; k < f.size(); k++) q.push_back(f[k]);
    got_q.delete();
    send(p, 0, 1'b0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    send(q, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== ew[0]) begin
      n_fail++;
      $display("FAIL to15.wr: got %0d writes expected %h", got_q.size(), ew[0]);
    end
    n_chk++;
    if ({load_done, load_err, core_hold} !== {st == 1, st == 2, st != 1}) begin
      n_fail++;
      $display("FAIL to15.status: got %b%b%b expected st=%0d",
               load_done, load_err, core_hold, st);
    end
    pulse_start();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_length();
    test_back_to_back();
    test_midreset();
`ifdef TEXT_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
